// File: rtl/game_pkg.sv
// Shared game definitions: raster geometry widths, colour indices and game-state encodings.
package game_pkg;

    // Raster coordinate width and pixel colour-index width minus one
    localparam int CORDW = 10;
    localparam int CIDXW = 3;

    // Colour index constants used by the sprite generators
    localparam logic [3:0] CIDX_BG       = 4'b0000;
    localparam logic [3:0] CIDX_PLAYER   = 4'b0100;
    localparam logic [3:0] CIDX_OBSTACLE = 4'b1000;
    localparam logic [3:0] CIDX_TEXT     = 4'b1111;

    // Top-level game state encoding
    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_PLAY = 2'd1,
        GS_OVER = 2'd2
    } game_state_t;

    // Add a small count to a 16-bit counter, sticking at all-ones instead of wrapping
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/obstacle_slot.sv
// One obstacle slot: occupancy, horizontal position, lane, and the pixel-coverage compare.
module obstacle_slot #(
    parameter int CORDW      = 10,
    parameter int X_START    = 700,
    parameter int X_END      = 80,
    parameter int OBS_W      = 16,
    parameter int OBS_H      = 8,
    parameter int LANE_Y0    = 160,
    parameter int LANE_PITCH = 45
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             clr,
    input  logic             run,
    input  logic             tick_move,
    input  logic [3:0]       speed,
    input  logic             spawn,
    input  logic [1:0]       spawn_lane,
    input  logic [CORDW-1:0] hc,
    input  logic [CORDW-1:0] vc,
    output logic             active,
    output logic             covered,
    output logic             retire
);
    import game_pkg::*;

    logic             active_reg;
    logic [CORDW-1:0] x_reg;
    logic [1:0]       lane_reg;
    logic [CORDW:0]   y_lo;

    // One extra bit on every compare so x+width and X_END+speed never wrap
    assign y_lo   = (CORDW+1)'(LANE_Y0) + (CORDW+1)'(lane_reg) * (CORDW+1)'(LANE_PITCH);
    assign active = active_reg;

    assign covered = active_reg
                  && ({1'b0, hc} >= {1'b0, x_reg})
                  && ({1'b0, hc} <= {1'b0, x_reg} + (CORDW+1)'(OBS_W - 1))
                  && ({1'b0, vc} >= y_lo)
                  && ({1'b0, vc} <= y_lo + (CORDW+1)'(OBS_H - 1));

    // x - speed <= X_END rewritten as x <= X_END + speed so nothing underflows
    assign retire = run && tick_move && active_reg
                 && ({1'b0, x_reg} <= (CORDW+1)'(X_END) + (CORDW+1)'(speed));

    // Slot state: restart/spawn reload the slot, a retiring move frees it, otherwise it slides left
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            active_reg <= 1'b0;
            x_reg      <= CORDW'(X_START);
            lane_reg   <= 2'd0;
        end else if (clr) begin
            active_reg <= 1'b0;
            x_reg      <= CORDW'(X_START);
            lane_reg   <= 2'd0;
        end else if (spawn) begin
            active_reg <= 1'b1;
            x_reg      <= CORDW'(X_START);
            lane_reg   <= spawn_lane;
        end else if (retire) begin
            active_reg <= 1'b0;
        end else if (run && tick_move && active_reg) begin
            x_reg      <= x_reg - CORDW'(speed);
        end
    end

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle scheduler: spawns obstacles into free slots, moves and retires them, draws them and flags collisions.
module obstacle_scheduler #(
    parameter int NSLOT      = 3,
    parameter int NLANE      = 3,
    parameter int CORDW      = game_pkg::CORDW,
    parameter int CIDXW      = game_pkg::CIDXW,
    parameter int COOLDOWN   = 18,
    parameter int X_START    = 700,
    parameter int X_END      = 80,
    parameter int OBS_W      = 16,
    parameter int OBS_H      = 8,
    parameter int LANE_Y0    = 160,
    parameter int LANE_PITCH = 45,
    parameter logic [CIDXW:0] COLOR = 4'b1000
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             run,
    input  logic             clr,
    input  logic             tick_spawn,
    input  logic             tick_move,
    input  logic [3:0]       speed,
    input  logic [12:0]      rand_val,
    input  logic [CORDW-1:0] hc,
    input  logic [CORDW-1:0] vc,
    input  logic             player_on,
    output logic [CIDXW:0]   obstacle_pix,
    output logic [NSLOT-1:0] active,
    output logic             hit,
    output logic [15:0]      passed
);
    import game_pkg::*;

    localparam int CDW = $clog2(COOLDOWN + 1);

    // Reject parameter sets the motion logic cannot handle
    generate
        if (X_START <= X_END) begin : g_bad_x
            $error("obstacle_scheduler: X_START must be greater than X_END");
        end
        if (NSLOT < 1 || NSLOT > 8) begin : g_bad_nslot
            $error("obstacle_scheduler: NSLOT must be 1..8");
        end
        if (NLANE < 1 || NLANE > 4) begin : g_bad_nlane
            $error("obstacle_scheduler: NLANE must be 1..4");
        end
    endgenerate

    logic [NSLOT-1:0] covered_w;
    logic [NSLOT-1:0] retire_w;
    logic [NSLOT-1:0] free_sel;
    logic             free_found;
    logic             spawn_go;
    logic [1:0]       spawn_lane;
    logic [3:0]       retire_cnt;
    logic [CDW-1:0]   cooldown_reg;
    logic [15:0]      passed_reg;
    logic             hit_reg;
    logic [CIDXW:0]   pix_reg;

    assign spawn_lane   = 2'(rand_val % 13'(NLANE));
    assign spawn_go     = run && tick_spawn && !clr && free_found
                       && (cooldown_reg == CDW'(COOLDOWN));
    assign passed       = passed_reg;
    assign hit          = hit_reg;
    assign obstacle_pix = pix_reg;

    // Lowest-index free slot, judged on occupancy before this edge so a retiring slot waits a cycle
    always_comb begin
        free_sel   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            if (!active[i] && !free_found) begin
                free_sel[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    // Number of slots leaving the field on this edge
    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < NSLOT; i++) begin
            retire_cnt = retire_cnt + 4'(retire_w[i]);
        end
    end

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
            obstacle_slot #(
                .CORDW      (CORDW),
                .X_START    (X_START),
                .X_END      (X_END),
                .OBS_W      (OBS_W),
                .OBS_H      (OBS_H),
                .LANE_Y0    (LANE_Y0),
                .LANE_PITCH (LANE_PITCH)
            ) u_slot (
                .CLK        (CLK),
                .RESET_N    (RESET_N),
                .clr        (clr),
                .run        (run),
                .tick_move  (tick_move),
                .speed      (speed),
                .spawn      (spawn_go && free_sel[gi]),
                .spawn_lane (spawn_lane),
                .hc         (hc),
                .vc         (vc),
                .active     (active[gi]),
                .covered    (covered_w[gi]),
                .retire     (retire_w[gi])
            );
        end
    endgenerate

    // Cooldown: counts spawn ticks up to COOLDOWN, holds there while full, clears on a spawn
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cooldown_reg <= '0;
        end else if (clr) begin
            cooldown_reg <= '0;
        end else if (spawn_go) begin
            cooldown_reg <= '0;
        end else if (run && tick_spawn && (cooldown_reg < CDW'(COOLDOWN))) begin
            cooldown_reg <= cooldown_reg + 1'b1;
        end
    end

    // Retired-obstacle score, saturating
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            passed_reg <= '0;
        end else if (clr) begin
            passed_reg <= '0;
        end else begin
            passed_reg <= sat_add16(passed_reg, retire_cnt);
        end
    end

    // Sticky collision flag: player pixel overlapping any obstacle pixel while running
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hit_reg <= 1'b0;
        end else if (clr) begin
            hit_reg <= 1'b0;
        end else if (run && player_on && (|covered_w)) begin
            hit_reg <= 1'b1;
        end
    end

    // Obstacle pixel, one cycle behind hc/vc, drawn even while the game is paused
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pix_reg <= '0;
        end else if (clr) begin
            pix_reg <= '0;
        end else begin
            pix_reg <= (|covered_w) ? COLOR : '0;
        end
    end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: per-cycle comparison against a slot-list game model plus pinned literal checks.
module tb_obstacle_scheduler;

    localparam int NSLOT      = 3;
    localparam int NLANE      = 3;
    localparam int COOLDOWN   = 18;
    localparam int X_START    = 700;
    localparam int X_END      = 80;
    localparam int OBS_W      = 16;
    localparam int OBS_H      = 8;
    localparam int LANE_Y0    = 160;
    localparam int LANE_PITCH = 45;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        run = 1'b0;
    logic        clr = 1'b0;
    logic        tick_spawn = 1'b0;
    logic        tick_move = 1'b0;
    logic [3:0]  speed = 4'd0;
    logic [12:0] rand_val = 13'd0;
    logic [9:0]  hc = 10'd0;
    logic [9:0]  vc = 10'd0;
    logic        player_on = 1'b0;
    logic [3:0]  obstacle_pix;
    logic [NSLOT-1:0] active;
    logic        hit;
    logic [15:0] passed;

    int n_cmp = 0;
    int n_err = 0;

    obstacle_scheduler dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .run          (run),
        .clr          (clr),
        .tick_spawn   (tick_spawn),
        .tick_move    (tick_move),
        .speed        (speed),
        .rand_val     (rand_val),
        .hc           (hc),
        .vc           (vc),
        .player_on    (player_on),
        .obstacle_pix (obstacle_pix),
        .active       (active),
        .hit          (hit),
        .passed       (passed)
    );

    always #5 CLK = ~CLK;

    // Internal slot position/lane and cooldown, observed for comparison only
    logic [9:0] dut_x    [NSLOT];
    logic [1:0] dut_lane [NSLOT];
    logic [4:0] dut_cd;
    assign dut_cd = dut.cooldown_reg;
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_peek
            assign dut_x[gi]    = dut.g_slot[gi].u_slot.x_reg;
            assign dut_lane[gi] = dut.g_slot[gi].u_slot.lane_reg;
        end
    endgenerate

    // ---------------- game model ----------------
    bit m_act  [NSLOT];
    int m_x    [NSLOT];
    int m_lane [NSLOT];
    int m_cd, m_passed, m_pix;
    bit m_hit;

    function automatic bit m_covered(input int h, input int v);
        for (int i = 0; i < NSLOT; i++) begin
            int y;
            y = LANE_Y0 + m_lane[i] * LANE_PITCH;
            if (m_act[i] && h >= m_x[i] && h <= m_x[i] + OBS_W - 1 && v >= y && v <= y + OBS_H - 1)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int m_active_bits();
        int r;
        r = 0;
        for (int i = 0; i < NSLOT; i++) if (m_act[i]) r += (1 << i);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSLOT; i++) begin
            m_act[i] = 1'b0; m_x[i] = X_START; m_lane[i] = 0;
        end
        m_cd = 0; m_passed = 0; m_hit = 1'b0; m_pix = 0;
    endtask

    task automatic model_step();
        bit cov;
        bit was [NSLOT];
        int first_free;
        if (clr) begin
            model_reset();
            return;
        end
        cov = m_covered(int'(hc), int'(vc));
        for (int i = 0; i < NSLOT; i++) was[i] = m_act[i];
        m_pix = cov ? 8 : 0;
        if (run && player_on && cov) m_hit = 1'b1;
        if (run && tick_move) begin
            for (int i = 0; i < NSLOT; i++) begin
                if (was[i]) begin
                    if (m_x[i] - int'(speed) <= X_END) begin
                        m_act[i] = 1'b0;
                        if (m_passed < 65535) m_passed++;
                    end else begin
                        m_x[i] = m_x[i] - int'(speed);
                    end
                end
            end
        end
        if (run && tick_spawn) begin
            first_free = -1;
            for (int i = 0; i < NSLOT; i++) if (!was[i] && first_free < 0) first_free = i;
            if (m_cd == COOLDOWN && first_free >= 0) begin
                m_act[first_free]  = 1'b1;
                m_x[first_free]    = X_START;
                m_lane[first_free] = int'(rand_val) % NLANE;
                m_cd = 0;
            end else if (m_cd < COOLDOWN) begin
                m_cd++;
            end
        end
    endtask

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) model_reset();
        else          model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Every cycle out of reset, the DUT must agree with the model
    always @(negedge CLK) begin
        if (RESET_N) begin
            chk("active", 32'(active), 32'(m_active_bits()));
            chk("passed", 32'(passed), 32'(m_passed));
            chk("hit", 32'(hit), 32'(m_hit));
            chk("pix", 32'(obstacle_pix), 32'(m_pix));
            chk("cooldown", 32'(dut_cd), 32'(m_cd));
            for (int i = 0; i < NSLOT; i++) begin
                if (m_act[i]) begin
                    chk($sformatf("x[%0d]", i), 32'(dut_x[i]), 32'(m_x[i]));
                    chk($sformatf("lane[%0d]", i), 32'(dut_lane[i]), 32'(m_lane[i]));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic spawn_pulses(input int n, input int rv);
        for (int k = 0; k < n; k++) begin
            rand_val = 13'(rv); tick_spawn = 1'b1; step(); tick_spawn = 1'b0;
        end
    endtask

    task automatic move_pulses(input int n, input int spd);
        speed = 4'(spd);
        for (int k = 0; k < n; k++) begin
            tick_move = 1'b1; step(); tick_move = 1'b0;
        end
    endtask

    task automatic restart();
        clr = 1'b1; step(); clr = 1'b0;
    endtask

    initial begin
        step(); step();
        RESET_N = 1'b1;
        #1;
        $display("txn reset released");
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_passed", 32'(passed), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_pix", 32'(obstacle_pix), 32'd0);
        chk("rst_cooldown", 32'(dut_cd), 32'd0);
        step();

        // First spawn after a full cooldown, lane from rand_val
        run = 1'b1;
        spawn_pulses(18, 0);
        $display("txn 18 spawn ticks");
        chk("cd_saturated", 32'(dut_cd), 32'd18);
        chk("no_early_spawn", 32'(active), 32'd0);
        spawn_pulses(1, 5);
        $display("txn spawn rand_val=5");
        chk("spawn_active", 32'(active), 32'd1);
        chk("spawn_lane", 32'(dut_lane[0]), 32'd2);
        chk("spawn_x", 32'(dut_x[0]), 32'd700);
        chk("spawn_cd_clear", 32'(dut_cd), 32'd0);

        // Paused game freezes motion and cooldown
        run = 1'b0;
        move_pulses(1, 4);
        spawn_pulses(1, 0);
        $display("txn paused move/spawn");
        chk("freeze_x", 32'(dut_x[0]), 32'd700);
        chk("freeze_cd", 32'(dut_cd), 32'd0);
        run = 1'b1;

        // Drawing window of an obstacle at x=300, lane 0
        restart();
        spawn_pulses(18, 0);
        spawn_pulses(1, 3);
        move_pulses(50, 8);
        $display("txn obstacle at x=300 lane 0");
        chk("x300", 32'(dut_x[0]), 32'd300);
        vc = 10'd160;
        for (int h = 298; h <= 317; h++) begin
            hc = 10'(h);
            step();
            $display("txn pixel hc=%0d vc=160", h);
            chk("pix_scan", 32'(obstacle_pix), (h >= 300 && h <= 315) ? 32'd8 : 32'd0);
        end
        hc = 10'd300; vc = 10'd167; step();
        chk("pix_bottom_row", 32'(obstacle_pix), 32'd8);
        vc = 10'd168; step();
        chk("pix_below", 32'(obstacle_pix), 32'd0);
        chk("hit_before", 32'(hit), 32'd0);

        // Collision is sticky until restart
        hc = 10'd305; vc = 10'd163; player_on = 1'b1; step();
        player_on = 1'b0; hc = 10'd0; vc = 10'd0;
        $display("txn player overlap hc=305 vc=163");
        chk("hit_set", 32'(hit), 32'd1);
        step(); step(); step();
        chk("hit_sticky", 32'(hit), 32'd1);
        restart();
        $display("txn restart");
        chk("clr_hit", 32'(hit), 32'd0);
        chk("clr_active", 32'(active), 32'd0);
        chk("clr_passed", 32'(passed), 32'd0);

        // Approach and retire at the X_END boundary
        spawn_pulses(19, 0);
        move_pulses(40, 15);
        chk("x100", 32'(dut_x[0]), 32'd100);
        for (int k = 1; k <= 4; k++) begin
            move_pulses(1, 4);
            $display("txn move speed=4 #%0d", k);
            chk("x_step", 32'(dut_x[0]), 32'(100 - 4 * k));
        end
        move_pulses(1, 4);
        $display("txn move to retire");
        chk("retire_active", 32'(active), 32'd0);
        chk("retire_passed", 32'(passed), 32'd1);

        // Two obstacles retiring together; paused move leaves x alone
        restart();
        spawn_pulses(19, 0);
        spawn_pulses(19, 1);
        move_pulses(41, 15);
        chk("pair_active", 32'(active), 32'd3);
        chk("pair_x", 32'(dut_x[1]), 32'd85);
        run = 1'b0;
        move_pulses(1, 15);
        chk("pause_x", 32'(dut_x[0]), 32'd85);
        run = 1'b1;
        move_pulses(1, 15);
        $display("txn double retire");
        chk("pair_retired", 32'(active), 32'd0);
        chk("pair_passed", 32'(passed), 32'd2);

        // Full slots: spawn waits, freed slot1 not reused on its retire edge, taken next tick
        restart();
        spawn_pulses(19, 0);
        move_pulses(40, 15);
        spawn_pulses(19, 0);
        move_pulses(2, 15);
        chk("s0_gone", 32'(active), 32'd2);
        chk("s1_x670", 32'(dut_x[1]), 32'd670);
        spawn_pulses(19, 0);
        spawn_pulses(19, 2);
        chk("all_busy", 32'(active), 32'd7);
        spawn_pulses(19, 0);
        $display("txn spawn ticks while full");
        chk("full_active", 32'(active), 32'd7);
        chk("full_cd", 32'(dut_cd), 32'd18);
        move_pulses(39, 15);
        speed = 4'd15; tick_move = 1'b1; tick_spawn = 1'b1; step();
        tick_move = 1'b0; tick_spawn = 1'b0;
        $display("txn slot1 retires with spawn tick");
        chk("no_same_cycle_reuse", 32'(active), 32'd5);
        chk("full_passed", 32'(passed), 32'd2);
        spawn_pulses(1, 0);
        $display("txn spawn into slot1");
        chk("slot1_reused", 32'(active), 32'd7);
        chk("slot1_x", 32'(dut_x[1]), 32'd700);
        chk("slot1_cd", 32'(dut_cd), 32'd0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 The block SHALL have parameter NSLOT, default 3, number of concurrent obstacle slots (1..8).
REQ-002 The block SHALL have parameter NLANE, default 3, number of vertical lanes (1..4).
REQ-003 The block SHALL have parameters CORDW=10, coordinate width, and CIDXW=3, pixel index width minus one.
REQ-004 The block SHALL have parameters COOLDOWN=18 (spawn ticks between spawns), X_START=700, X_END=80, OBS_W=16, OBS_H=8, LANE_Y0=160, LANE_PITCH=45, and COLOR=4'b1000.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset; the ports are named CLK and RESET_N.
REQ-006 The block SHALL have the following ports:
- CLK  in  1  system clock.
- RESET_N  in  1  async active-low reset.
- run  in  1  game running; enables spawn and move.
- clr  in  1  synchronous game restart.
- tick_spawn  in  1  one-cycle spawn-timer enable.
- tick_move  in  1  one-cycle motion enable.
- speed  in  4  pixels moved per tick_move.
- rand_val  in  13  LFSR value.
- hc, vc  in  CORDW each  raster position.
- player_on  in  1  player sprite covers the current hc/vc.
- obstacle_pix  out  CIDXW+1  obstacle pixel.
- active  out  NSLOT  slot occupancy.
- hit  out  1  sticky collision flag.
- passed  out  16  count of obstacles retired.

Function
REQ-007 All state SHALL be clocked on CLK only; tick inputs are enables, never clocks.
REQ-008 The cooldown counter SHALL increment on each tick_spawn while run=1, saturating at COOLDOWN.
REQ-009 When cooldown==COOLDOWN, run=1, tick_spawn=1 and any slot is free, the lowest-index free slot SHALL be allocated: x=X_START, lane=rand_val % NLANE, and cooldown cleared to 0.
REQ-010 With no slot free, the counter SHALL hold at COOLDOWN, and the spawn SHALL occur on the first tick_spawn after a slot frees.
REQ-011 On tick_move with run=1, each active slot SHALL take x = x - speed; a slot whose x - speed <= X_END (unsigned compare, no wrap) SHALL retire instead, clearing active[i].
REQ-012 passed SHALL increase by the number of slots retired in that cycle, saturating at 16'hFFFF.
REQ-013 Free-slot selection SHALL use occupancy before the current cycle; a slot retiring in the same cycle is not re-allocated until the next cycle.
REQ-014 Lane y SHALL be LANE_Y0 + lane*LANE_PITCH.
REQ-015 A pixel is covered when, for some active slot, x <= hc <= x+OBS_W-1 and y <= vc <= y+OBS_H-1.
REQ-016 obstacle_pix SHALL be registered, 1-cycle latency from hc/vc: COLOR if covered, else 0.
REQ-017 hit SHALL set when run=1, player_on=1 and the current hc/vc is covered; it holds until clr or reset.
REQ-018 With run=0, slots, x and cooldown SHALL freeze, and obstacle_pix SHALL continue to reflect frozen slots.
REQ-019 When clr=1, then on that edge all slots, cooldown, passed, hit and obstacle_pix SHALL clear; clr overrides spawn, move and hit in the same cycle.

Reset
REQ-020 On RESET_N low, the block SHALL asynchronously reset to: active=0, all x=X_START, lanes=0, cooldown=0, passed=0, hit=0, obstacle_pix=0.
REQ-021 A reset asserted mid-motion SHALL abandon all slots with no retire counted.

Structure
REQ-022 A shared package game_pkg SHALL hold CORDW, CIDXW, the colour index constants and the game-state encodings.
REQ-023 Per-slot x, lane and active state plus its coverage compare SHALL be a sub-module obstacle_slot, instantiated NSLOT times by generate.
REQ-024 Spawn arbitration, the cooldown counter, passed, hit and the pixel register SHALL live in the top level.
REQ-025 An elaboration check SHALL reject X_START <= X_END.

Verification
REQ-026 Reset, run=1, 18 tick_spawn pulses, then a 19th with rand_val=5 -> slot0 active, lane 2 (y=250), x=700, cooldown=0.
REQ-027 One active slot at x=100, speed=4, tick_move pulses -> x=96, 92, 88, 84, then retire (84-4=80<=80); active=0, passed=1.
REQ-028 All 3 slots busy, cooldown saturated -> no spawn; slot1 retires -> the next tick_spawn allocates slot1.
REQ-029 Slot at x=300 lane 0; drive hc=300..315, vc=160 -> obstacle_pix=4'b1000 one cycle later; hc=316 -> 0.
REQ-030 player_on=1 at hc=305, vc=163 with that slot -> hit=1 and stays 1; clr pulse -> hit=0, active=0, passed=0.
REQ-031 Two slots retire on the same tick_move -> passed increments by 2; run=0 during tick_move -> x is unchanged.
